// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 single-precision divider.
// The mantissa quotient comes from a restoring divider that produces one bit
// per cycle. A single rounding cycle then normalises the quotient and rounds
// it to nearest-even. Denormal operands are flushed to zero.
// Handshake: start is sampled only in IDLE, busy is high while the divide is
// in flight, and done is a one-cycle pulse.
module fp_div_seq #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic        DivByZero
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_ROUND  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  localparam logic [4:0] CNT_LAST  = 5'(QBITS - 1);

  logic [1:0]        state_r;
  logic              sign_r;
  logic [7:0]        ea_r;
  logic [7:0]        eb_r;
  logic [23:0]       mb_r;
  logic [24:0]       rem_r;
  logic [QBITS-1:0]  quo_r;
  logic [4:0]        count_r;
  logic              busy_r;
  logic              done_r;
  logic [31:0]       result_r;
  logic              exc_r;
  logic              ovf_r;
  logic              unf_r;
  logic              dbz_r;

  logic [7:0]        a_exp_s;
  logic [7:0]        b_exp_s;
  logic              spec_exc_s;
  logic              spec_dbz_s;
  logic              spec_zero_s;
  logic              in_sign_s;

  logic              ge_s;
  logic [24:0]       rem_diff_s;
  logic [24:0]       rem_next_s;

  logic [22:0]       mant_s;
  logic              guard_s;
  logic              sticky_s;
  logic signed [9:0] exp_s;
  logic              round_up_s;
  logic [23:0]       mant_inc_s;
  logic signed [9:0] exp_fin_s;
  logic [31:0]       round_result_s;
  logic              round_ovf_s;
  logic              round_unf_s;

  assign a_exp_s     = a_operand[30:23];
  assign b_exp_s     = b_operand[30:23];
  assign spec_exc_s  = (a_exp_s == 8'hFF) || (b_exp_s == 8'hFF);
  assign spec_dbz_s  = (b_exp_s == 8'h00);
  assign spec_zero_s = (a_exp_s == 8'h00);
  assign in_sign_s   = a_operand[31] ^ b_operand[31];

  // One restoring-division step: conditional subtract, then shift the remainder left.
  always_comb begin
    ge_s       = (rem_r >= {1'b0, mb_r});
    rem_diff_s = rem_r;
    if (ge_s) begin
      rem_diff_s = rem_r - {1'b0, mb_r};
    end else begin
      rem_diff_s = rem_r;
    end
    rem_next_s = rem_diff_s << 25'd1;
  end

  // Normalise the quotient, round to nearest-even and classify the exponent range.
  always_comb begin
    mant_s   = 23'd0;
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    exp_s    = 10'sd0;
    if (quo_r[25]) begin
      mant_s   = quo_r[24:2];
      guard_s  = quo_r[1];
      sticky_s = quo_r[0] | (rem_r != 25'd0);
      exp_s    = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + 10'sd127;
    end else begin
      mant_s   = quo_r[23:1];
      guard_s  = quo_r[0];
      sticky_s = (rem_r != 25'd0);
      exp_s    = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + 10'sd126;
    end
    round_up_s = guard_s & (sticky_s | mant_s[0]);
    // A carry out of the 23-bit fraction leaves it all zero and bumps the exponent.
    mant_inc_s = {1'b0, mant_s} + {23'd0, round_up_s};
    exp_fin_s  = exp_s + $signed({9'd0, mant_inc_s[23]});
    round_ovf_s    = 1'b0;
    round_unf_s    = 1'b0;
    round_result_s = 32'd0;
    if (exp_fin_s >= 10'sd255) begin
      round_ovf_s    = 1'b1;
      round_result_s = {sign_r, 8'hFF, 23'd0};
    end else if (exp_fin_s <= 10'sd0) begin
      round_unf_s    = 1'b1;
      round_result_s = {sign_r, 31'd0};
    end else begin
      round_result_s = {sign_r, exp_fin_s[7:0], mant_inc_s[22:0]};
    end
  end

  // Control FSM and datapath registers: accept, iterate, round, report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      sign_r   <= 1'b0;
      ea_r     <= 8'd0;
      eb_r     <= 8'd0;
      mb_r     <= 24'd0;
      rem_r    <= 25'd0;
      quo_r    <= '0;
      count_r  <= 5'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
      exc_r    <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sign_r  <= in_sign_s;
            ea_r    <= a_exp_s;
            eb_r    <= b_exp_s;
            mb_r    <= {1'b1, b_operand[22:0]};
            rem_r   <= {1'b0, 1'b1, a_operand[22:0]};
            quo_r   <= '0;
            count_r <= 5'd0;
            exc_r   <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            dbz_r   <= 1'b0;
            // Special cases resolve immediately; Exception outranks DivByZero.
            if (spec_exc_s) begin
              exc_r    <= 1'b1;
              result_r <= 32'd0;
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
            end else if (spec_dbz_s) begin
              dbz_r    <= 1'b1;
              result_r <= {in_sign_s, 8'hFF, 23'd0};
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
            end else if (spec_zero_s) begin
              result_r <= {in_sign_s, 31'd0};
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              busy_r  <= 1'b1;
              state_r <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          rem_r   <= rem_next_s;
          quo_r   <= {quo_r[QBITS-2:0], ge_s};
          count_r <= count_r + 5'd1;
          if (count_r == CNT_LAST) begin
            state_r <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          result_r <= round_result_s;
          ovf_r    <= round_ovf_s;
          unf_r    <= round_unf_s;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign Exception = exc_r;
  assign Overflow  = ovf_r;
  assign Underflow = unf_r;
  assign DivByZero = dbz_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed, self-checking bench for fp_div_seq.
// Expected results go into a scoreboard queue when an operation is started
// and are popped and compared when done is observed.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        Exception;
  logic        Overflow;
  logic        Underflow;
  logic        DivByZero;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   failed = 0;

  fp_div_seq #(.QBITS(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .DivByZero (DivByZero)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {28'd0, Exception, Overflow, Underflow, DivByZero};
  endfunction

  // Start one operation, optionally pulse start again at cycles inj1/inj2
  // (counted in clocks after the accepting edge), then score it on done.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef, input int el,
                        input int ebusy, input int inj1, input int inj2);
    exp_t e;
    exp_t got;
    int   lat;
    int   bcnt;
    bit   seen;
    e.res = er;
    e.flg = ef;
    e.lat = el;
    e.busy_cycles = ebusy;
    sb.push_back(e);
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    start     = 1'b1;
    lat  = 0;
    bcnt = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
      if (lat == inj1 || lat == inj2) begin
        start     = 1'b1;
        a_operand = 32'h3F800000;
        b_operand = 32'h40400000;
      end else begin
        start = 1'b0;
      end
    end
    chk({name, ":done_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      got = sb.pop_front();
      chk({name, ":result"}, result, got.res);
      chk({name, ":flags"}, flags_now(), {28'd0, got.flg});
      chk({name, ":latency"}, lat, got.lat);
      chk({name, ":busy_cycles"}, bcnt, got.busy_cycles);
    end
    @(negedge clk);
    start = 1'b0;
    chk({name, ":done_pulse_width"}, {31'd0, done}, 32'd0);
    chk({name, ":idle_after_done"}, {31'd0, busy}, 32'd0);
    chk({name, ":result_held"}, result, er);
  endtask

  initial begin
    int dcnt;
    rst_n     = 1'b0;
    start     = 1'b0;
    a_operand = 32'd0;
    b_operand = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset:result", result, 32'd0);
    chk("reset:flags", flags_now(), 32'd0);
    chk("reset:busy", {31'd0, busy}, 32'd0);
    chk("reset:done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("6/2",   32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 27, 0, 0);
    run_op("1/3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, 27, 0, 0);
    run_op("-6/2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 28, 27, 0, 0);
    run_op("1/1",   32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 28, 27, 0, 0);
    run_op("2/3",   32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000, 28, 27, 0, 0);
    run_op("1/0",   32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 1, 0, 0, 0);
    run_op("inf/1", 32'h7F800000, 32'h3F800000, 32'h00000000, 4'b1000, 1, 0, 0, 0);
    run_op("inf/0", 32'h7F800000, 32'h00000000, 32'h00000000, 4'b1000, 1, 0, 0, 0);
    run_op("-0/2",  32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1, 0, 0, 0);
    run_op("ovf",   32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 28, 27, 0, 0);

    // Abort an operation with reset at cycle 10; outputs clear at once and no done follows.
    @(negedge clk);
    a_operand = 32'h3F800000;
    b_operand = 32'h40400000;
    start     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("abort:result", result, 32'd0);
    chk("abort:flags", flags_now(), 32'd0);
    chk("abort:busy", {31'd0, busy}, 32'd0);
    chk("abort:done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort:no_activity", dcnt, 32'd0);

    run_op("1/3_after_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, 27, 0, 0);
    run_op("unf",   32'h00800000, 32'h7F000000, 32'h00000000, 4'b0010, 28, 27, 0, 0);
    run_op("6/2_ignored_starts", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 27, 5, 27);
    run_op("6/2_start_in_done",  32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 27, 28, 0);
    run_op("1/0_start_in_done",  32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0001, 1, 0, 1, 0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
